tug_game_ctrl: RTL and testbench

- Round controller for the tug-of-war game.
- Edge-detects the two player buttons and moves a single rope LED across a 7-LED bar.
- Detects the winner, keeps per-player win tallies, and drives the blink/enable control.
- Sits directly upstream of the LED output multiplexer: `score` and `led_control` feed it unchanged. `led_control[1]` is the display-enable bit that the mux gates on.

---
 rtl/tug_game_ctrl_if.sv | 29 ++
 rtl/tug_game_ctrl.sv | 126 ++++++++++++
 tb/tb_tug_game_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tug_game_ctrl_if.sv
// Player and display bus of the tug-of-war round controller.
//   btn_l/btn_r  : debounced player buttons (level)
//   start/clear  : one-cycle round start / tally clear pulses
//   score        : one-hot rope position, bit 6 = left end
//   led_control  : [1] display enable (blinks on win), [0] winner side
//   winner_valid : round decided
//   wins_l/wins_r: saturating round tallies
// master drives the controls (board/bench); slave is the controller.
interface tug_game_ctrl_if;
  logic       btn_l;
  logic       btn_r;
  logic       start;
  logic       clear;
  logic [6:0] score;
  logic [1:0] led_control;
  logic       winner_valid;
  logic [3:0] wins_l;
  logic [3:0] wins_r;

  modport master (
    output btn_l, btn_r, start, clear,
    input  score, led_control, winner_valid, wins_l, wins_r
  );

  modport slave (
    input  btn_l, btn_r, start, clear,
    output score, led_control, winner_valid, wins_l, wins_r
  );
endinterface

// File: rtl/tug_game_ctrl.sv
// Tug-of-war round controller.
// Edge-detects both player buttons, walks a single rope LED across a 7-LED
// bar, declares the winner when the rope reaches an end, keeps saturating
// win tallies and blinks the display enable while a winner is shown.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   io    : tug_game_ctrl_if.slave (buttons, start/clear, score/LED outputs)
// Every output is a flop; score is re-encoded from the next position so it
// is never a decode behind the pos register.
module tug_game_ctrl #(
  parameter int BLINK_DIV = 25000000,
  parameter int CENTER    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  tug_game_ctrl_if.slave io
);

  localparam int             CW    = $clog2(BLINK_DIV);
  localparam logic [2:0]     CTR   = 3'(CENTER);
  localparam logic [CW-1:0]  BLAST = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAY, WIN_L, WIN_R} state_t;

  state_t        state;
  logic [2:0]    pos;
  logic [6:0]    score;
  logic [1:0]    led_ctl;
  logic          win_vld;
  logic [3:0]    wins_l, wins_r;
  logic [CW-1:0] blink;
  logic          btn_l_q, btn_r_q;

  logic       press_l, press_r;
  logic [2:0] pos_mv;

  function automatic logic [6:0] onehot(input logic [2:0] p);
    return 7'd1 << p;
  endfunction

  assign press_l = io.btn_l & ~btn_l_q;
  assign press_r = io.btn_r & ~btn_r_q;

  // Only used when exactly one press is present.
  always_comb begin
    pos_mv = pos;
    if (press_l) pos_mv = pos + 3'd1;
    else         pos_mv = pos - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pos     <= CTR;
      score   <= onehot(CTR);
      led_ctl <= 2'b10;
      win_vld <= 1'b0;
      wins_l  <= '0;
      wins_r  <= '0;
      blink   <= '0;
      // History starts high: a button held through reset must be released
      // before it can register a press.
      btn_l_q <= 1'b1;
      btn_r_q <= 1'b1;
    end else begin
      btn_l_q <= io.btn_l;
      btn_r_q <= io.btn_r;
      if (io.clear) begin
        state   <= IDLE;
        pos     <= CTR;
        score   <= onehot(CTR);
        led_ctl <= 2'b10;
        win_vld <= 1'b0;
        wins_l  <= '0;
        wins_r  <= '0;
        blink   <= '0;
      end else if (io.start) begin
        state   <= PLAY;
        pos     <= CTR;
        score   <= onehot(CTR);
        led_ctl <= 2'b10;
        win_vld <= 1'b0;
        blink   <= '0;
      end else begin
        case (state)
          PLAY: begin
            // Simultaneous presses cancel out.
            if (press_l ^ press_r) begin
              pos   <= pos_mv;
              score <= onehot(pos_mv);
              if (pos_mv == 3'd6) begin
                state   <= WIN_L;
                win_vld <= 1'b1;
                led_ctl <= 2'b10;
                blink   <= '0;
                if (wins_l != 4'hf) wins_l <= wins_l + 4'd1;
              end else if (pos_mv == 3'd0) begin
                state   <= WIN_R;
                win_vld <= 1'b1;
                led_ctl <= 2'b11;
                blink   <= '0;
                if (wins_r != 4'hf) wins_r <= wins_r + 4'd1;
              end
            end
          end
          WIN_L, WIN_R: begin
            if (blink == BLAST) begin
              blink      <= '0;
              led_ctl[1] <= ~led_ctl[1];
            end else begin
              blink <= blink + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io.score        = score;
  assign io.led_control  = led_ctl;
  assign io.winner_valid = win_vld;
  assign io.wins_l       = wins_l;
  assign io.wins_r       = wins_r;

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Directed bench for tug_game_ctrl: each step drives the controls, queues
// the expected outputs, and checks them 1 ns after the next rising edge.
module tb_tug_game_ctrl;

  localparam logic [6:0] C = 7'b0001000;

  typedef struct packed {
    logic [6:0] score;
    logic [1:0] led;
    logic       wv;
    logic [3:0] wl;
    logic [3:0] wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int compared = 0;
  int mismatched = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  tug_game_ctrl_if bus();

  tug_game_ctrl #(.BLINK_DIV(4), .CENTER(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    compared++;
    assert (bus.score === e.score) else begin
      mismatched++;
      $error("FAIL %s score got %b want %b", t, bus.score, e.score);
    end
    compared++;
    assert (bus.led_control === e.led) else begin
      mismatched++;
      $error("FAIL %s led_control got %b want %b", t, bus.led_control, e.led);
    end
    compared++;
    assert (bus.winner_valid === e.wv) else begin
      mismatched++;
      $error("FAIL %s winner_valid got %b want %b", t, bus.winner_valid, e.wv);
    end
    compared++;
    assert (bus.wins_l === e.wl) else begin
      mismatched++;
      $error("FAIL %s wins_l got %0d want %0d", t, bus.wins_l, e.wl);
    end
    compared++;
    assert (bus.wins_r === e.wr) else begin
      mismatched++;
      $error("FAIL %s wins_r got %0d want %0d", t, bus.wins_r, e.wr);
    end
  endtask

  task automatic expect_now(input logic [6:0] s, input logic [1:0] lc,
                            input logic wv, input logic [3:0] wl,
                            input logic [3:0] wr, input string tag);
    exp_q.push_back('{s, lc, wv, wl, wr});
    tag_q.push_back(tag);
  endtask

  task automatic step(input logic l, input logic r, input logic st,
                      input logic cl, input logic [6:0] s,
                      input logic [1:0] lc, input logic wv,
                      input logic [3:0] wl, input logic [3:0] wr,
                      input string tag);
    @(negedge clk);
    bus.btn_l = l;
    bus.btn_r = r;
    bus.start = st;
    bus.clear = cl;
    expect_now(s, lc, wv, wl, wr, tag);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] wl;
    bus.btn_l = 1'b1;
    bus.btn_r = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    expect_now(C, 2'b10, 1'b0, 4'd0, 4'd0, "reset");
    check();
    @(negedge clk) rst_n = 1'b1;

    // held button through reset never counts; IDLE anyway
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, C, 2'b10, 0, 0, 0, "held");
    step(0, 0, 0, 0, C, 2'b10, 0, 0, 0, "release");

    // left walk to a win
    step(0, 0, 1, 0, C,          2'b10, 0, 0, 0, "start");
    step(1, 0, 0, 0, 7'b0010000, 2'b10, 0, 0, 0, "l1");
    step(0, 0, 0, 0, 7'b0010000, 2'b10, 0, 0, 0, "l1_rel");
    step(1, 0, 0, 0, 7'b0100000, 2'b10, 0, 0, 0, "l2");
    step(0, 0, 0, 0, 7'b0100000, 2'b10, 0, 0, 0, "l2_rel");
    step(1, 0, 0, 0, 7'b1000000, 2'b10, 1, 1, 0, "win_l");
    step(0, 0, 0, 0, 7'b1000000, 2'b10, 1, 1, 0, "win_l_hold");

    // simultaneous presses cancel
    step(0, 0, 1, 0, C,          2'b10, 0, 1, 0, "restart");
    step(1, 1, 0, 0, C,          2'b10, 0, 1, 0, "both");
    step(0, 0, 0, 0, C,          2'b10, 0, 1, 0, "both_rel");
    step(0, 1, 0, 0, 7'b0000100, 2'b10, 0, 1, 0, "r1");
    step(0, 0, 0, 0, 7'b0000100, 2'b10, 0, 1, 0, "r1_rel");

    // right win and blink with BLINK_DIV = 4
    step(0, 1, 0, 0, 7'b0000010, 2'b10, 0, 1, 0, "r2");
    step(0, 0, 0, 0, 7'b0000010, 2'b10, 0, 1, 0, "r2_rel");
    step(0, 1, 0, 0, 7'b0000001, 2'b11, 1, 1, 1, "win_r");
    step(1, 0, 0, 0, 7'b0000001, 2'b11, 1, 1, 1, "blink_on1");
    step(0, 0, 0, 0, 7'b0000001, 2'b11, 1, 1, 1, "blink_on2");
    step(1, 1, 0, 0, 7'b0000001, 2'b11, 1, 1, 1, "blink_on3");
    step(0, 0, 0, 0, 7'b0000001, 2'b01, 1, 1, 1, "blink_off0");
    step(1, 0, 0, 0, 7'b0000001, 2'b01, 1, 1, 1, "blink_off1");
    step(0, 0, 0, 0, 7'b0000001, 2'b01, 1, 1, 1, "blink_off2");
    step(0, 1, 0, 0, 7'b0000001, 2'b01, 1, 1, 1, "blink_off3");
    step(0, 0, 0, 0, 7'b0000001, 2'b11, 1, 1, 1, "blink_on_again");
    step(0, 0, 1, 0, C,          2'b10, 0, 1, 1, "start_after_win");

    // sixteen left wins, tally saturates at 15
    wl = 4'd1;
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, 0, C,          2'b10, 0, wl, 1, "sat_start");
      step(1, 0, 0, 0, 7'b0010000, 2'b10, 0, wl, 1, "sat_l1");
      step(0, 0, 0, 0, 7'b0010000, 2'b10, 0, wl, 1, "sat_rel1");
      step(1, 0, 0, 0, 7'b0100000, 2'b10, 0, wl, 1, "sat_l2");
      step(0, 0, 0, 0, 7'b0100000, 2'b10, 0, wl, 1, "sat_rel2");
      if (wl != 4'hf) wl = wl + 4'd1;
      step(1, 0, 0, 0, 7'b1000000, 2'b10, 1, wl, 1, "sat_win");
    end

    // clear beats start; IDLE ignores presses
    step(0, 0, 1, 1, C, 2'b10, 0, 0, 0, "clear_start");
    step(1, 0, 0, 0, C, 2'b10, 0, 0, 0, "idle_ignore");
    step(0, 0, 0, 0, C, 2'b10, 0, 0, 0, "idle_rel");

    // async reset mid-PLAY at pos 5
    step(0, 0, 1, 0, C,          2'b10, 0, 0, 0, "rst_start");
    step(1, 0, 0, 0, 7'b0010000, 2'b10, 0, 0, 0, "rst_l1");
    step(0, 0, 0, 0, 7'b0010000, 2'b10, 0, 0, 0, "rst_rel1");
    step(1, 0, 0, 0, 7'b0100000, 2'b10, 0, 0, 0, "rst_l2");
    step(0, 0, 0, 0, 7'b0100000, 2'b10, 0, 0, 0, "rst_rel2");
    #2 rst_n = 1'b0;
    #1;
    expect_now(C, 2'b10, 0, 0, 0, "async_reset");
    check();
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 0, C, 2'b10, 0, 0, 0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
